// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle for the sequential ALU.
//   in_valid/in_ready : request handshake (control, in0, in1 travel with it)
//   out_valid/out_ready : result handshake (dout, flags travel with it)
// master = requester/consumer side, slave = the ALU.
interface alu_seq_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       control;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] dout;
    logic [4:0]       flags;

    modport master (
        output in_valid, control, in0, in1, out_ready,
        input  in_ready, out_valid, dout, flags
    );

    modport slave (
        input  in_valid, control, in0, in1, out_ready,
        output in_ready, out_valid, dout, flags
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: single-request ALU. Arithmetic/logic ops finish on the accept
// edge; shifts walk one bit per cycle through a work register.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - synchronous active-high reset
//   bus  - alu_seq_if.slave: request (in_valid/in_ready/control/in0/in1),
//          result (out_valid/out_ready/dout/flags = {illegal,ovf,carry,neg,zero})
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic      clk,
    input logic      rst,
    alu_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

    state_t           state;
    logic [WIDTH-1:0] work;
    logic [SHW-1:0]   count;
    logic [1:0]       sh_op;     // control[1:0] of the shift: SLL, SRL, SRA, ROL
    logic             sh_carry;  // last bit shifted/rotated out so far
    logic             out_valid_r;
    logic [WIDTH-1:0] dout_r;
    logic [4:0]       flags_r;

    logic [WIDTH-1:0] a, b;
    logic [WIDTH-1:0] sc_res;
    logic             sc_carry, sc_ovf, sc_ill;
    logic             accept, is_shift;

    assign a = bus.in0;
    assign b = bus.in1;

    // Ready in IDLE, or in DONE when the held result is being drained now.
    assign bus.in_ready  = !rst && (state == IDLE || (state == DONE && bus.out_ready));
    assign accept        = bus.in_valid && bus.in_ready;
    assign is_shift      = (bus.control[3:2] == 2'b10);
    assign bus.out_valid = out_valid_r;
    assign bus.dout      = dout_r;
    assign bus.flags     = flags_r;

    // Single-cycle result path; illegal opcodes leave sc_res at zero.
    always_comb begin
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        sc_ill   = 1'b0;
        case (bus.control)
            4'd0: begin
                {sc_carry, sc_res} = {1'b0, a} + {1'b0, b};
                sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sc_res[WIDTH-1] != a[WIDTH-1]);
            end
            4'd1: sc_res = a & b;
            4'd2: sc_res = a | b;
            4'd3: sc_res = a ^ b;
            4'd4: begin
                sc_res   = a - b;
                sc_carry = (a < b);
                sc_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sc_res[WIDTH-1] != a[WIDTH-1]);
            end
            4'd5: sc_res = ~(a & b);
            4'd6: sc_res = ~(a | b);
            4'd7: sc_res = ~(a ^ b);
            4'd12, 4'd13, 4'd14, 4'd15: sc_ill = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
            dout_r      <= '0;
            flags_r     <= '0;
            work        <= '0;
            count       <= '0;
            sh_op       <= '0;
            sh_carry    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        if (is_shift) begin
                            // Shifts always pass through SHIFT, even amount 0,
                            // so latency is amount+1 edges after accept.
                            work        <= a;
                            count       <= b[SHW-1:0];
                            sh_op       <= bus.control[1:0];
                            sh_carry    <= 1'b0;
                            out_valid_r <= 1'b0;
                            state       <= SHIFT;
                        end else begin
                            dout_r      <= sc_res;
                            flags_r     <= {sc_ill, sc_ovf, sc_carry, sc_res[WIDTH-1], sc_res == '0};
                            out_valid_r <= 1'b1;
                            state       <= DONE;
                        end
                    end else if (state == DONE && bus.out_ready) begin
                        // dout/flags intentionally keep the consumed result.
                        out_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                SHIFT: begin
                    if (count == '0) begin
                        dout_r      <= work;
                        flags_r     <= {1'b0, 1'b0, sh_carry, work[WIDTH-1], work == '0};
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end else begin
                        count <= count - CNT_ONE;
                        case (sh_op)
                            2'd0: begin
                                work     <= {work[WIDTH-2:0], 1'b0};
                                sh_carry <= work[WIDTH-1];
                            end
                            2'd1: begin
                                work     <= {1'b0, work[WIDTH-1:1]};
                                sh_carry <= work[0];
                            end
                            2'd2: begin
                                work     <= {work[WIDTH-1], work[WIDTH-1:1]};
                                sh_carry <= work[0];
                            end
                            2'd3: begin
                                work     <= {work[WIDTH-2:0], work[WIDTH-1]};
                                sh_carry <= work[WIDTH-1];
                            end
                            default: ;
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with literal expectations, plus a
// transaction-level reference model checked every cycle.
module tb_alu_seq;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(16)) bus ();
    alu_seq #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference result {flags, dout} computed straight from the op definitions.
    function automatic logic [20:0] model(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
        logic [15:0] r;
        logic        c, v, ill;
        int          amt, s;
        logic [16:0] w;
        r = '0; c = 0; v = 0; ill = 0;
        amt = int'(b[3:0]);
        case (op)
            4'd0: begin
                w = {1'b0, a} + {1'b0, b}; r = w[15:0]; c = w[16];
                s = int'($signed(a)) + int'($signed(b)); v = (s > 32767) || (s < -32768);
            end
            4'd1: r = a & b;
            4'd2: r = a | b;
            4'd3: r = a ^ b;
            4'd4: begin
                r = a - b; c = (a < b);
                s = int'($signed(a)) - int'($signed(b)); v = (s > 32767) || (s < -32768);
            end
            4'd5: r = ~(a & b);
            4'd6: r = ~(a | b);
            4'd7: r = ~(a ^ b);
            4'd8: begin r = a << amt; c = (amt != 0) ? a[16-amt] : 1'b0; end
            4'd9: begin r = a >> amt; c = (amt != 0) ? a[amt-1] : 1'b0; end
            4'd10: begin r = $signed(a) >>> amt; c = (amt != 0) ? a[amt-1] : 1'b0; end
            4'd11: begin r = (a << amt) | (a >> (16 - amt)); c = (amt != 0) ? r[0] : 1'b0; end
            default: ill = 1;
        endcase
        return {ill, v, c, r[15], r == 16'h0, r};
    endfunction

    // Compare process: one request in flight, result visible from ready_at.
    initial begin
        int          n = 0;
        int          ready_at = 0;
        logic        pend = 0;
        logic [20:0] pres = '0;
        logic [20:0] last = '0;
        logic        ev, er;
        logic [20:0] shown;
        @(posedge clk);
        forever begin
            @(negedge clk);
            n++;
            ev = pend && (n >= ready_at);
            er = !rst && (!pend || (ev && bus.out_ready));
            shown = ev ? pres : last;
            chk("m_out_valid", {31'b0, bus.out_valid}, {31'b0, ev});
            chk("m_in_ready", {31'b0, bus.in_ready}, {31'b0, er});
            chk("m_dout", {16'b0, bus.dout}, {16'b0, shown[15:0]});
            chk("m_flags", {27'b0, bus.flags}, {27'b0, shown[20:16]});
            if (rst) begin
                pend = 0;
                last = '0;
            end else begin
                if (ev && bus.out_ready) begin
                    last = pres;
                    pend = 0;
                end
                if (bus.in_valid && er) begin
                    pend = 1;
                    pres = model(bus.control, bus.in0, bus.in1);
                    ready_at = n + ((bus.control[3:2] == 2'b10) ? int'(bus.in1[3:0]) + 2 : 1);
                end
            end
        end
    end

    // Hold a request until accepted; returns on posedge+1 of the accept edge.
    task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        output int tries);
        bit ok = 0;
        bus.in_valid = 1'b1;
        bus.control  = op;
        bus.in0      = a;
        bus.in1      = b;
        tries = 0;
        while (!ok && tries < 50) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) ok = 1;
            else tries++;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got no in_ready expected in_ready within 50 cycles");
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        // Scramble idle inputs; they must not affect the request in flight.
        bus.control = 4'($urandom);
        bus.in0     = 16'($urandom);
        bus.in1     = 16'($urandom);
    endtask

    // Wait for out_valid; edges = posedges after the accept edge before it rose.
    task automatic result(input string nm, input int edges, input logic [15:0] d,
                          input logic [4:0] f);
        int n = 0;
        bit got = 0;
        while (!got && n < 60) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) got = 1;
            else n++;
        end
        chk({nm, "_lat"}, n, edges);
        chk({nm, "_dout"}, {16'b0, bus.dout}, {16'b0, d});
        chk({nm, "_flags"}, {27'b0, bus.flags}, {27'b0, f});
        @(posedge clk); #1;
    endtask

    initial begin
        int t;
        int hi;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.control = '0; bus.in0 = '0; bus.in1 = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'b0, bus.out_valid}, 0);
        chk("rst_in_ready", {31'b0, bus.in_ready}, 0);
        chk("rst_dout", {16'b0, bus.dout}, 0);
        chk("rst_flags", {27'b0, bus.flags}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        send(4'd0, 16'h7FFF, 16'h0001, t);
        chk("first_accept_tries", t, 0);
        result("add_ovf", 0, 16'h8000, 5'b01010);
        send(4'd4, 16'h0003, 16'h0005, t); result("sub_borrow", 0, 16'hFFFE, 5'b00110);
        send(4'd4, 16'h0005, 16'h0005, t); result("sub_zero", 0, 16'h0000, 5'b00001);
        send(4'd10, 16'h8001, 16'h0003, t); result("sra3", 4, 16'hF000, 5'b00010);
        send(4'd11, 16'h8001, 16'h0001, t); result("rol1", 2, 16'h0003, 5'b00100);
        send(4'd8, 16'h0001, 16'hFFF0, t); result("sll0", 1, 16'h0001, 5'b00000);
        send(4'd13, 16'h1234, 16'h5678, t); result("illegal", 0, 16'h0000, 5'b10001);
        send(4'd9, 16'h8000, 16'h000F, t); result("srl15", 16, 16'h0001, 5'b00000);
        send(4'd0, 16'hFFFF, 16'h0001, t); result("add_carry", 0, 16'h0000, 5'b00101);
        send(4'd6, 16'h0000, 16'h0000, t); result("nor", 0, 16'hFFFF, 5'b00010);
        send(4'd7, 16'h00F0, 16'h0F00, t); result("xnor", 0, 16'hF00F, 5'b00010);

        // Back-to-back XORs: each accepted on the first try means no bubble.
        for (int i = 0; i < 4; i++) begin
            send(4'd3, 16'(16'h1111 * i), 16'h00FF, t);
            chk("b2b_tries", t, 0);
        end
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.control = 4'd0; bus.in0 = 16'h0001; bus.in1 = 16'h0002;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", {31'b0, bus.in_ready}, 0);
            chk("stall_out_valid", {31'b0, bus.out_valid}, 1);
            chk("stall_dout", {16'b0, bus.dout}, 32'h33CC);
            chk("stall_flags", {27'b0, bus.flags}, 0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        send(4'd0, 16'h0001, 16'h0002, t);
        chk("after_stall_tries", t, 0);
        result("after_stall", 0, 16'h0003, 5'b00000);

        // Reset in the middle of a long shift discards it.
        send(4'd8, 16'h0001, 16'h000A, t);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_dout", {16'b0, bus.dout}, 0);
        chk("rst_mid_flags", {27'b0, bus.flags}, 0);
        chk("rst_mid_in_ready", {31'b0, bus.in_ready}, 1);
        hi = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) hi++;
        end
        chk("rst_mid_no_valid", hi, 0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
